// File: rtl/str_ram_arbiter_pkg.sv
// rtl/str_ram_arbiter_pkg.sv - shared types and constants for the string RAM arbiter
package str_ram_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/str_ram_arbiter_if.sv
// rtl/str_ram_arbiter_if.sv - requester and string RAM signal bundle
interface str_ram_arbiter_if
  import str_ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_gnt;
  logic              r0_rvalid;
  logic [DATA_W-1:0] r0_rdata;

  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_gnt;
  logic              r1_rvalid;
  logic [DATA_W-1:0] r1_rdata;

  logic              ram_init;
  logic              ram_rd;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output ram_init, ram_rd, ram_wr, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  ram_init, ram_rd, ram_wr, ram_addr, ram_din,
    output ram_dout
  );

endinterface

// File: rtl/str_ram_arbiter_rr_arb2.sv
// rtl/str_ram_arbiter_rr_arb2.sv - two-way round-robin / fixed-priority pick
module rr_arb2
  import str_ram_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic       win,
  output logic       any
);

  always_comb begin
    any = |req;
    win = REQ0;
    if (fixed) begin
      win = req[0] ? REQ0 : (req[1] ? REQ1 : REQ0);
    end else if (&req) begin
      // contention: whoever was not served last goes next
      win = ~last;
    end else begin
      win = req[1] ? REQ1 : REQ0;
    end
  end

endmodule

// File: rtl/str_ram_arbiter.sv
// rtl/str_ram_arbiter.sv - serialises two requesters onto one registered-read string RAM
module str_ram_arbiter
  import str_ram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIXED_PRIO = 0
) (
  input logic              clk,
  input logic              rst,
  str_ram_arbiter_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  logic              winner;
  logic              cmd_we;
  logic              last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic arb_win;
  logic arb_any;
  logic gnt0;
  logic gnt1;
  logic rvalid0;
  logic rvalid1;
  logic ram_init_c;
  logic ram_rd_c;
  logic ram_wr_c;

  rr_arb2 u_arb (
    .req   ({bus.r1_req, bus.r0_req}),
    .last  (last_grant),
    .fixed (FIXED_PRIO != 0),
    .win   (arb_win),
    .any   (arb_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      winner     <= REQ0;
      cmd_we     <= 1'b0;
      last_grant <= REQ1;
      addr_q     <= '0;
      din_q      <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (arb_any) begin
            winner <= arb_win;
            cmd_we <= (arb_win == REQ1) ? bus.r1_we    : bus.r0_we;
            addr_q <= (arb_win == REQ1) ? bus.r1_addr  : bus.r0_addr;
            din_q  <= (arb_win == REQ1) ? bus.r1_wdata : bus.r0_wdata;
          end
        end
        CMD: last_grant <= winner;
        RDWAIT: begin
          // RAM output is valid for exactly this cycle; keep it per requester
          if (winner == REQ1) rdata1_q <= bus.ram_dout;
          else                rdata0_q <= bus.ram_dout;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    ram_init_c = 1'b0;
    ram_rd_c   = 1'b0;
    ram_wr_c   = 1'b0;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    rvalid0    = 1'b0;
    rvalid1    = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) state_nxt = CMD;
      end
      CMD: begin
        ram_init_c = 1'b1;
        ram_wr_c   = cmd_we;
        ram_rd_c   = ~cmd_we;
        gnt0       = (winner == REQ0);
        gnt1       = (winner == REQ1);
        state_nxt  = cmd_we ? IDLE : RDWAIT;
      end
      RDWAIT: state_nxt = RESP;
      RESP: begin
        rvalid0   = (winner == REQ0);
        rvalid1   = (winner == REQ1);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.r0_gnt    = gnt0;
  assign bus.r1_gnt    = gnt1;
  assign bus.r0_rvalid = rvalid0;
  assign bus.r1_rvalid = rvalid1;
  assign bus.r0_rdata  = rdata0_q;
  assign bus.r1_rdata  = rdata1_q;
  assign bus.ram_init  = ram_init_c;
  assign bus.ram_rd    = ram_rd_c;
  assign bus.ram_wr    = ram_wr_c;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_din   = din_q;

endmodule

// File: tb/tb_str_ram_arbiter.sv
// tb/tb_str_ram_arbiter.sv - self-checking bench for str_ram_arbiter
module tb_str_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  str_ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_rr ();
  str_ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_fp ();

  str_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) dut_rr (
    .clk (clk), .rst (rst), .bus (bus_rr.slave)
  );
  str_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) dut_fp (
    .clk (clk), .rst (rst), .bus (bus_fp.slave)
  );

  int errors = 0;
  int checks = 0;

  // String RAMs: write at the edge, registered read
  logic [7:0] mem_rr [256];
  logic [7:0] mem_fp [256];
  always @(posedge clk) begin
    if (bus_rr.ram_init && bus_rr.ram_wr) mem_rr[bus_rr.ram_addr] = bus_rr.ram_din;
    if (bus_rr.ram_init && bus_rr.ram_rd) bus_rr.ram_dout <= mem_rr[bus_rr.ram_addr];
    if (bus_fp.ram_init && bus_fp.ram_wr) mem_fp[bus_fp.ram_addr] = bus_fp.ram_din;
    if (bus_fp.ram_init && bus_fp.ram_rd) bus_fp.ram_dout <= mem_fp[bus_fp.ram_addr];
  end

  wire [38:0] outs_rr = {bus_rr.r0_gnt, bus_rr.r1_gnt, bus_rr.r0_rvalid, bus_rr.r1_rvalid,
                         bus_rr.r0_rdata, bus_rr.r1_rdata, bus_rr.ram_init, bus_rr.ram_rd,
                         bus_rr.ram_wr, bus_rr.ram_addr, bus_rr.ram_din};
  wire [38:0] outs_fp = {bus_fp.r0_gnt, bus_fp.r1_gnt, bus_fp.r0_rvalid, bus_fp.r1_rvalid,
                         bus_fp.r0_rdata, bus_fp.r1_rdata, bus_fp.ram_init, bus_fp.ram_rd,
                         bus_fp.ram_wr, bus_fp.ram_addr, bus_fp.ram_din};

  // Reference model for the random run: memory contents by grant order
  bit         mon_on = 1'b0;
  int         gcnt0 = 0;
  int         gcnt1 = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];

  always @(negedge clk) begin
    if (mon_on) begin
      checks++;
      if ((bus_rr.ram_rd && bus_rr.ram_wr) || (bus_rr.r0_gnt && bus_rr.r1_gnt)) begin
        errors++;
        $display("FAIL exclusive: rd=%b wr=%b gnt0=%b gnt1=%b required no overlap",
                 bus_rr.ram_rd, bus_rr.ram_wr, bus_rr.r0_gnt, bus_rr.r1_gnt);
      end
      if (bus_rr.r0_gnt) begin
        gcnt0++;
        checks++;
        if (!bus_rr.r0_req || bus_rr.ram_addr !== bus_rr.r0_addr || bus_rr.ram_wr !== bus_rr.r0_we) begin
          errors++;
          $display("FAIL gnt0_cmd: req=%b addr=%h wr=%b required req=1 addr=%h wr=%b",
                   bus_rr.r0_req, bus_rr.ram_addr, bus_rr.ram_wr, bus_rr.r0_addr, bus_rr.r0_we);
        end
        if (bus_rr.r0_we) ref_mem[bus_rr.r0_addr] = bus_rr.r0_wdata;
        else exp0.push_back(ref_mem[bus_rr.r0_addr]);
      end
      if (bus_rr.r1_gnt) begin
        gcnt1++;
        checks++;
        if (!bus_rr.r1_req || bus_rr.ram_addr !== bus_rr.r1_addr || bus_rr.ram_wr !== bus_rr.r1_we) begin
          errors++;
          $display("FAIL gnt1_cmd: req=%b addr=%h wr=%b required req=1 addr=%h wr=%b",
                   bus_rr.r1_req, bus_rr.ram_addr, bus_rr.ram_wr, bus_rr.r1_addr, bus_rr.r1_we);
        end
        if (bus_rr.r1_we) ref_mem[bus_rr.r1_addr] = bus_rr.r1_wdata;
        else exp1.push_back(ref_mem[bus_rr.r1_addr]);
      end
      if (bus_rr.r0_rvalid) begin
        checks++;
        if (exp0.size() == 0) begin
          errors++;
          $display("FAIL rvalid0_unexpected: rdata=%h required no rvalid", bus_rr.r0_rdata);
        end else if (bus_rr.r0_rdata !== exp0[0]) begin
          errors++;
          $display("FAIL rdata0: got %h required %h", bus_rr.r0_rdata, exp0[0]);
        end
        if (exp0.size() != 0) void'(exp0.pop_front());
      end
      if (bus_rr.r1_rvalid) begin
        checks++;
        if (exp1.size() == 0) begin
          errors++;
          $display("FAIL rvalid1_unexpected: rdata=%h required no rvalid", bus_rr.r1_rdata);
        end else if (bus_rr.r1_rdata !== exp1[0]) begin
          errors++;
          $display("FAIL rdata1: got %h required %h", bus_rr.r1_rdata, exp1[0]);
        end
        if (exp1.size() != 0) void'(exp1.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (outs_rr !== 39'd0 || outs_fp !== 39'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: rr=%h fp=%h required 0", i, outs_rr, outs_fp);
      end
    end
  endtask

  task automatic test_write_read();
    bus_rr.r0_req = 1'b1; bus_rr.r0_we = 1'b1; bus_rr.r0_addr = 8'h10; bus_rr.r0_wdata = 8'h41;
    @(negedge clk);
    checks++;
    if (!bus_rr.r0_gnt || !bus_rr.ram_init || !bus_rr.ram_wr || bus_rr.ram_rd ||
        bus_rr.ram_addr !== 8'h10 || bus_rr.ram_din !== 8'h41) begin
      errors++;
      $display("FAIL write_cmd: gnt=%b init=%b wr=%b rd=%b addr=%h din=%h required 1 1 1 0 10 41",
               bus_rr.r0_gnt, bus_rr.ram_init, bus_rr.ram_wr, bus_rr.ram_rd, bus_rr.ram_addr, bus_rr.ram_din);
    end
    bus_rr.r0_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_rr.r0_gnt || bus_rr.ram_init || mem_rr[8'h10] !== 8'h41) begin
      errors++;
      $display("FAIL write_done: gnt=%b init=%b mem=%h required 0 0 41",
               bus_rr.r0_gnt, bus_rr.ram_init, mem_rr[8'h10]);
    end
    bus_rr.r0_req = 1'b1; bus_rr.r0_we = 1'b0;
    @(negedge clk);
    checks++;
    if (!bus_rr.r0_gnt || !bus_rr.ram_rd || bus_rr.ram_wr) begin
      errors++;
      $display("FAIL read_cmd: gnt=%b rd=%b wr=%b required 1 1 0", bus_rr.r0_gnt, bus_rr.ram_rd, bus_rr.ram_wr);
    end
    bus_rr.r0_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_rr.r0_rvalid || bus_rr.ram_init) begin
      errors++;
      $display("FAIL read_wait: rvalid=%b init=%b required 0 0", bus_rr.r0_rvalid, bus_rr.ram_init);
    end
    @(negedge clk);
    checks++;
    if (!bus_rr.r0_rvalid || bus_rr.r1_rvalid || bus_rr.r0_rdata !== 8'h41) begin
      errors++;
      $display("FAIL read_resp: rvalid0=%b rvalid1=%b rdata=%h required 1 0 41",
               bus_rr.r0_rvalid, bus_rr.r1_rvalid, bus_rr.r0_rdata);
    end
    @(negedge clk);
    checks++;
    if (bus_rr.r0_rvalid || bus_rr.r0_rdata !== 8'h41) begin
      errors++;
      $display("FAIL read_hold: rvalid=%b rdata=%h required 0 41", bus_rr.r0_rvalid, bus_rr.r0_rdata);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int pend;
    int nrv;
    do_reset();
    mem_rr[8'h00] = 8'h11;
    mem_rr[8'hFF] = 8'h22;
    bus_rr.r0_req = 1'b1; bus_rr.r0_we = 1'b0; bus_rr.r0_addr = 8'h00;
    bus_rr.r1_req = 1'b1; bus_rr.r1_we = 1'b0; bus_rr.r1_addr = 8'hFF;
    pend = -1;
    nrv = 0;
    for (int i = 0; i < 40 && nrv < 4; i++) begin
      @(negedge clk);
      if (bus_rr.r0_gnt) begin order.push_back(0); pend = 0; end
      if (bus_rr.r1_gnt) begin order.push_back(1); pend = 1; end
      if (bus_rr.r0_rvalid) begin
        nrv++;
        checks++;
        if (pend != 0 || bus_rr.r0_rdata !== 8'h11) begin
          errors++;
          $display("FAIL rr_rvalid0: owner=%0d rdata=%h required owner 0 rdata 11", pend, bus_rr.r0_rdata);
        end
      end
      if (bus_rr.r1_rvalid) begin
        nrv++;
        checks++;
        if (pend != 1 || bus_rr.r1_rdata !== 8'h22) begin
          errors++;
          $display("FAIL rr_rvalid1: owner=%0d rdata=%h required owner 1 rdata 22", pend, bus_rr.r1_rdata);
        end
      end
    end
    bus_rr.r0_req = 1'b0;
    bus_rr.r1_req = 1'b0;
    checks++;
    if (nrv != 4) begin
      errors++;
      $display("FAIL rr_responses: got %0d required 4", nrv);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= order.size()) begin
        errors++;
        $display("FAIL rr_order[%0d]: missing grant required %0d", k, k % 2);
      end else if (order[k] != k % 2) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d required %0d", k, order[k], k % 2);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fixed_prio();
    int n0;
    int n1;
    int got;
    int wait_n;
    do_reset();
    bus_fp.r0_req = 1'b1; bus_fp.r0_we = 1'b0; bus_fp.r0_addr = 8'h01;
    bus_fp.r1_req = 1'b1; bus_fp.r1_we = 1'b0; bus_fp.r1_addr = 8'h02;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus_fp.r0_gnt) n0++;
      if (bus_fp.r1_gnt) n1++;
    end
    checks++;
    if (n1 != 0 || n0 != 6) begin
      errors++;
      $display("FAIL fp_starve: r0 grants=%0d r1 grants=%0d required 6 and 0", n0, n1);
    end
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      if (bus_fp.r1_gnt) n1++;
      if (bus_fp.r0_gnt) got = 1;
    end
    bus_fp.r0_req = 1'b0;
    wait_n = 0;
    got = 0;
    for (int i = 1; i <= 8 && got == 0; i++) begin
      @(negedge clk);
      if (bus_fp.r1_gnt) begin got = 1; wait_n = i; end
    end
    bus_fp.r1_req = 1'b0;
    checks++;
    if (got == 0 || wait_n > 5 || n1 != 0) begin
      errors++;
      $display("FAIL fp_handover: granted=%0d after %0d cycles early_r1=%0d required granted within 5",
               got, wait_n, n1);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    int got;
    do_reset();
    bus_rr.r1_req = 1'b1; bus_rr.r1_we = 1'b0; bus_rr.r1_addr = 8'h05;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      if (bus_rr.r1_gnt) got = 1;
    end
    bus_rr.r1_req = 1'b0;
    checks++;
    if (got == 0) begin
      errors++;
      $display("FAIL mid_read_gnt: r1_gnt not seen required 1");
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (outs_rr !== 39'd0) begin
      errors++;
      $display("FAIL mid_read_reset: outputs=%h required 0", outs_rr);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus_rr.r1_rvalid || bus_rr.ram_init) begin
        errors++;
        $display("FAIL mid_read_no_rvalid: rvalid1=%b init=%b required 0 0", bus_rr.r1_rvalid, bus_rr.ram_init);
      end
    end
    bus_rr.r0_req = 1'b1; bus_rr.r0_we = 1'b0; bus_rr.r0_addr = 8'h06;
    bus_rr.r1_req = 1'b1;
    @(negedge clk);
    checks++;
    if (!bus_rr.r0_gnt || bus_rr.r1_gnt) begin
      errors++;
      $display("FAIL mid_read_first: gnt0=%b gnt1=%b required 1 0", bus_rr.r0_gnt, bus_rr.r1_gnt);
    end
    bus_rr.r0_req = 1'b0;
    bus_rr.r1_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic drive(input int id, input int n, output int done);
    int gap;
    int got;
    logic we;
    logic [7:0] a;
    logic [7:0] d;
    done = 0;
    for (int t = 0; t < n; t++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      #1;
      we = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 255));
      d  = 8'($urandom_range(0, 255));
      if (id == 0) begin
        bus_rr.r0_we = we; bus_rr.r0_addr = a; bus_rr.r0_wdata = d; bus_rr.r0_req = 1'b1;
      end else begin
        bus_rr.r1_we = we; bus_rr.r1_addr = a; bus_rr.r1_wdata = d; bus_rr.r1_req = 1'b1;
      end
      got = 0;
      for (int c = 0; c < 40 && got == 0; c++) begin
        @(negedge clk);
        got = (id == 0) ? int'(bus_rr.r0_gnt) : int'(bus_rr.r1_gnt);
      end
      #1;
      if (id == 0) bus_rr.r0_req = 1'b0;
      else         bus_rr.r1_req = 1'b0;
      checks++;
      if (got == 0) begin
        errors++;
        $display("FAIL rand_gnt_timeout: requester %0d txn %0d no gnt required gnt", id, t);
      end else begin
        done++;
      end
    end
  endtask

  task automatic test_random();
    int d0;
    int d1;
    logic [7:0] v;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom_range(0, 255));
      mem_rr[i]  = v;
      ref_mem[i] = v;
    end
    gcnt0 = 0;
    gcnt1 = 0;
    exp0.delete();
    exp1.delete();
    mon_on = 1'b1;
    fork
      drive(0, 500, d0);
      drive(1, 500, d1);
    join
    repeat (6) @(negedge clk);
    mon_on = 1'b0;
    checks++;
    if (gcnt0 != d0 || gcnt1 != d1 || d0 + d1 != 1000) begin
      errors++;
      $display("FAIL rand_gnt_count: gnts=%0d/%0d accepted=%0d/%0d required equal and 1000 total",
               gcnt0, gcnt1, d0, d1);
    end
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL rand_missing_rvalid: pending=%0d/%0d required 0/0", exp0.size(), exp1.size());
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus_rr.r0_req = 1'b0; bus_rr.r0_we = 1'b0; bus_rr.r0_addr = '0; bus_rr.r0_wdata = '0;
    bus_rr.r1_req = 1'b0; bus_rr.r1_we = 1'b0; bus_rr.r1_addr = '0; bus_rr.r1_wdata = '0;
    bus_fp.r0_req = 1'b0; bus_fp.r0_we = 1'b0; bus_fp.r0_addr = '0; bus_fp.r0_wdata = '0;
    bus_fp.r1_req = 1'b0; bus_fp.r1_we = 1'b0; bus_fp.r1_addr = '0; bus_fp.r1_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem_rr[i] = 8'h00;
      mem_fp[i] = 8'h00;
    end
    @(negedge clk);
    test_reset();
    test_write_read();
    test_round_robin();
    test_fixed_prio();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
